// File: rtl/odd_count_pkg.sv
// Shared types, constants and the odd-sequence predictor for the odd-count checker.
// The predictor wraps 1111->0001 going up and 0001->1111 going down.
package odd_count_pkg;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FAULT  = 2'd2
    } state_e;

    localparam logic [3:0] ODD_MIN = 4'b0001;
    localparam logic [3:0] ODD_MAX = 4'b1111;

    function automatic logic [3:0] next_odd(input logic [3:0] count, input logic dir);
        if (dir) begin
            return (count == ODD_MAX) ? ODD_MIN : count + 4'd2;
        end else begin
            return (count == ODD_MIN) ? ODD_MAX : count - 4'd2;
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear in the same cycle as an
// increment leaves the count at 1.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] base;

    always_comb begin
        base  = clr_i ? '0 : cnt_q;
        cnt_d = base;
        if (inc_i && (base != {W{1'b1}})) begin
            cnt_d = base + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/odd_count_checker.sv
// Monitors an odd-only up/down counter: locks on the first odd sample, then flags
// any sample that breaks the predicted sequence and counts legal wraps.
module odd_count_checker
    import odd_count_pkg::*;
#(
    parameter int ERR_CNT_W  = 4,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic [3:0]            Count,
    input  logic                  UpOrDown,
    input  logic                  clear_err,
    output logic                  locked,
    output logic [3:0]            expected,
    output logic                  err_pulse,
    output logic                  seq_error,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic                  wrap_pulse,
    output logic                  wrap_dir,
    output logic [WRAP_CNT_W-1:0] wrap_count
);

    state_e                state_q, state_d;
    logic [3:0]            prev_q;
    logic                  dir_q;
    logic                  err_pulse_q, wrap_pulse_q, wrap_dir_q, seq_err_q;
    logic [WRAP_CNT_W-1:0] wrap_cnt_q;

    logic [3:0] predicted;
    logic       match;
    logic       load_smp, err_det, wrap_det;

    assign predicted = next_odd(prev_q, dir_q);
    assign match     = (Count == predicted);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC, ST_FAULT: if (Count[0]) state_d = ST_LOCKED;
            ST_LOCKED:         if (!match)   state_d = ST_FAULT;
            default:           state_d = ST_SYNC;
        endcase
    end

    always_comb begin
        load_smp = 1'b0;
        err_det  = 1'b0;
        wrap_det = 1'b0;
        case (state_q)
            ST_SYNC, ST_FAULT: load_smp = Count[0];
            ST_LOCKED: begin
                load_smp = match;
                err_det  = !match;
                // The wrap direction is the one stored with the previous sample.
                wrap_det = match && ((dir_q && prev_q == ODD_MAX) ||
                                     (!dir_q && prev_q == ODD_MIN));
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            prev_q       <= '0;
            dir_q        <= 1'b0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_dir_q   <= 1'b0;
            wrap_cnt_q   <= '0;
            seq_err_q    <= 1'b0;
        end else begin
            err_pulse_q  <= err_det;
            wrap_pulse_q <= wrap_det;
            seq_err_q    <= (seq_err_q && !clear_err) || err_det;
            if (load_smp) begin
                prev_q <= Count;
                dir_q  <= UpOrDown;
            end
            if (wrap_det) begin
                wrap_dir_q <= dir_q;
                wrap_cnt_q <= wrap_cnt_q + WRAP_CNT_W'(1);
            end
        end
    end

    sat_counter #(
        .W(ERR_CNT_W)
    ) u_err_cnt (
        .clk_i (Clk),
        .rst_i (reset),
        .inc_i (err_det),
        .clr_i (clear_err),
        .cnt_o (err_count)
    );

    assign locked     = (state_q == ST_LOCKED);
    assign expected   = locked ? predicted : 4'b0000;
    assign err_pulse  = err_pulse_q;
    assign seq_error  = seq_err_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_dir   = wrap_dir_q;
    assign wrap_count = wrap_cnt_q;

endmodule

// File: tb/tb_odd_count_checker.sv
// Directed-vector bench for odd_count_checker with hand-computed expectations.
module tb_odd_count_checker;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] Count = 4'b0000;
    logic       UpOrDown = 1'b1;
    logic       clear_err = 1'b0;
    logic       locked;
    logic [3:0] expected;
    logic       err_pulse;
    logic       seq_error;
    logic [3:0] err_count;
    logic       wrap_pulse;
    logic       wrap_dir;
    logic [7:0] wrap_count;

    int total = 0;
    int bad   = 0;

    odd_count_checker #(
        .ERR_CNT_W (4),
        .WRAP_CNT_W(8)
    ) dut (
        .Clk       (Clk),
        .reset     (reset),
        .Count     (Count),
        .UpOrDown  (UpOrDown),
        .clear_err (clear_err),
        .locked    (locked),
        .expected  (expected),
        .err_pulse (err_pulse),
        .seq_error (seq_error),
        .err_count (err_count),
        .wrap_pulse(wrap_pulse),
        .wrap_dir  (wrap_dir),
        .wrap_count(wrap_count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] c, input logic d, input logic clr);
        Count     = c;
        UpOrDown  = d;
        clear_err = clr;
        @(posedge Clk);
        #1;
        clear_err = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".locked"},     32'(locked),     32'd0);
        chk({tag, ".expected"},   32'(expected),   32'd0);
        chk({tag, ".err_pulse"},  32'(err_pulse),  32'd0);
        chk({tag, ".seq_error"},  32'(seq_error),  32'd0);
        chk({tag, ".err_count"},  32'(err_count),  32'd0);
        chk({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'd0);
        chk({tag, ".wrap_dir"},   32'(wrap_dir),   32'd0);
        chk({tag, ".wrap_count"}, 32'(wrap_count), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk_all_zero("rst");
        reset = 1'b0;

        // Lock and follow an up run
        step(4'b0001, 1'b1, 1'b0);
        chk("lock1.locked",   32'(locked),   32'd1);
        chk("lock1.expected", 32'(expected), 32'h3);
        step(4'b0011, 1'b1, 1'b0);
        chk("lock2.expected", 32'(expected), 32'h5);
        step(4'b0101, 1'b1, 1'b0);
        chk("lock3.expected", 32'(expected), 32'h7);
        chk("lock3.err",      32'(err_pulse), 32'd0);

        // Sequence error, then relock
        step(4'b1001, 1'b1, 1'b0);
        chk("err.pulse",    32'(err_pulse), 32'd1);
        chk("err.seq",      32'(seq_error), 32'd1);
        chk("err.cnt",      32'(err_count), 32'd1);
        chk("err.locked",   32'(locked),    32'd0);
        chk("err.expected", 32'(expected),  32'd0);
        step(4'b1011, 1'b1, 1'b0);
        chk("relock.locked",   32'(locked),    32'd1);
        chk("relock.pulse",    32'(err_pulse), 32'd0);
        chk("relock.seq",      32'(seq_error), 32'd1);
        chk("relock.expected", 32'(expected),  32'hD);

        // Up wrap
        step(4'b1101, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b0);
        chk("upw.pre_pulse", 32'(wrap_pulse), 32'd0);
        chk("upw.expected",  32'(expected),   32'h1);
        step(4'b0001, 1'b1, 1'b0);
        chk("upw.pulse", 32'(wrap_pulse), 32'd1);
        chk("upw.dir",   32'(wrap_dir),   32'd1);
        chk("upw.cnt",   32'(wrap_count), 32'd1);

        // Direction change, then down wrap
        step(4'b0011, 1'b0, 1'b0);
        chk("dn.pulse_gone", 32'(wrap_pulse), 32'd0);
        chk("dn.locked",     32'(locked),     32'd1);
        chk("dn.expected",   32'(expected),   32'h1);
        step(4'b0001, 1'b0, 1'b0);
        chk("dn.expected2",  32'(expected),   32'hF);
        step(4'b1111, 1'b0, 1'b0);
        chk("dnw.pulse", 32'(wrap_pulse), 32'd1);
        chk("dnw.dir",   32'(wrap_dir),   32'd0);
        chk("dnw.cnt",   32'(wrap_count), 32'd2);
        chk("dnw.err",   32'(err_pulse),  32'd0);

        // Clear errors on a good sample
        step(4'b1101, 1'b0, 1'b1);
        chk("clr.seq",    32'(seq_error), 32'd0);
        chk("clr.cnt",    32'(err_count), 32'd0);
        chk("clr.locked", 32'(locked),    32'd1);

        // Saturation over 20 errors
        for (int i = 0; i < 20; i++) begin
            step(4'b0000, 1'b1, 1'b0);
            chk($sformatf("sat%0d.pulse", i), 32'(err_pulse), 32'd1);
            chk($sformatf("sat%0d.cnt", i),   32'(err_count), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
            step(4'b0001, 1'b1, 1'b0);
            chk($sformatf("sat%0d.relock", i), 32'(locked), 32'd1);
        end
        step(4'b0000, 1'b1, 1'b1);
        chk("clrerr.cnt",   32'(err_count), 32'd1);
        chk("clrerr.seq",   32'(seq_error), 32'd1);
        chk("clrerr.pulse", 32'(err_pulse), 32'd1);

        // Even sample after reset stays in SYNC
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        step(4'b0110, 1'b1, 1'b0);
        chk("even.locked",   32'(locked),     32'd0);
        chk("even.err",      32'(err_pulse),  32'd0);
        chk("even.wrap",     32'(wrap_pulse), 32'd0);
        chk("even.expected", 32'(expected),   32'd0);
        step(4'b0111, 1'b1, 1'b0);
        chk("odd.locked",   32'(locked),   32'd1);
        chk("odd.expected", 32'(expected), 32'h9);

        // Three wraps, then asynchronous reset mid-cycle
        step(4'b1001, 1'b1, 1'b0);
        step(4'b1011, 1'b1, 1'b0);
        step(4'b1101, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0011, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1101, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        chk("w3.cnt", 32'(wrap_count), 32'd3);
        chk("w3.err", 32'(seq_error),  32'd0);
        #3 reset = 1'b1;
        #1;
        chk_all_zero("arst");
        #2 reset = 1'b0;
        step(4'b0101, 1'b1, 1'b0);
        chk("post.locked",   32'(locked),     32'd1);
        chk("post.expected", 32'(expected),   32'h7);
        chk("post.wcnt",     32'(wrap_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/odd_count_checker.md
ODD_COUNT_CHECKER -- requirements
Module: odd_count_checker

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 4, width of the saturating error counter.
REQ-002 SHALL have parameter WRAP_CNT_W, default 8, width of the modulo wrap counter.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port Count, input, 4, the value from the odd up/down counter being monitored.
REQ-006 SHALL have port UpOrDown, input, 1, the direction applied to that counter (1 = up, 0 = down).
REQ-007 SHALL have port clear_err, input, 1, a synchronous clear of seq_error and err_count.
REQ-008 SHALL have port locked, output, 1, high while in LOCKED.
REQ-009 SHALL have port expected, output, 4, the next odd value predicted for the following edge.
REQ-010 SHALL have port err_pulse, output, 1, a one-cycle pulse per detected sequence error.
REQ-011 SHALL have port seq_error, output, 1, a sticky error flag.
REQ-012 SHALL have port err_count, output, ERR_CNT_W, the saturating count of errors.
REQ-013 SHALL have port wrap_pulse, output, 1, a one-cycle pulse per legal wrap.
REQ-014 SHALL have port wrap_dir, output, 1, the direction of the last legal wrap (1 = up wrap).
REQ-015 SHALL have port wrap_count, output, WRAP_CNT_W, the modulo-2^WRAP_CNT_W count of legal wraps.

Function
REQ-016 SHALL sample Count and UpOrDown on every rising Clk edge; all outputs registered, visible the cycle after the sampling edge.
REQ-017 SHALL implement states SYNC, LOCKED, FAULT.
REQ-018 In SYNC: if sampled Count is odd (bit0=1), SHALL store Count/UpOrDown as previous sample and move to LOCKED; else stay, no pulses.
REQ-019 SHALL predict next(prev,dir): up -> prev+2 except 1111 -> 0001; down -> prev-2 except 0001 -> 1111; expected shows next() of the latest stored sample.
REQ-020 In LOCKED, when sampled Count equals expected: SHALL update previous sample and stay LOCKED.
REQ-021 In LOCKED, on a legal 1111 -> 0001 (dir up) or 0001 -> 1111 (dir down) transition: SHALL pulse wrap_pulse, set wrap_dir, increment wrap_count, wrapping to 0 after all-ones.
REQ-022 In LOCKED, when sampled Count differs from expected: SHALL pulse err_pulse, set seq_error, increment err_count (saturating at all-ones), and enter FAULT.
REQ-023 In FAULT: SHALL resynchronise exactly as SYNC (next odd sample -> LOCKED); even samples keep FAULT without further errors.
REQ-024 A direction change between edges SHALL be legal; the prediction uses the direction stored with the previous sample.
REQ-025 clear_err SHALL zero seq_error and err_count; when it coincides with a new error, the result SHALL be seq_error=1, err_count=1.
REQ-026 locked SHALL equal (state==LOCKED); expected SHALL read 0000 outside LOCKED.

Reset
REQ-027 reset SHALL asynchronously force state SYNC with all outputs 0: expected, err_count, wrap_count, all flags and pulses.
REQ-028 reset asserted mid-operation SHALL discard the stored sample; after release, the checker relocks on the first odd Count.

Structure
REQ-029 Package odd_count_pkg SHALL hold the state enum, constants ODD_MIN=4'b0001 and ODD_MAX=4'b1111, and the next_odd(count,dir) function.
REQ-030 A sub-module sat_counter (parameterised width, inc, clr, saturating) SHALL implement err_count; everything else stays in odd_count_checker.

Verification
REQ-031 Reset, then Count 0001,0011,0101, up -> locked=1 after the first edge, no err_pulse, expected=0111.
REQ-032 Up run 1101,1111,0001 -> one wrap_pulse, wrap_dir=1, wrap_count=1; down run 0011,0001,1111 -> wrap_dir=0, wrap_count=2.
REQ-033 Locked at 0101 up, then inject 1001 -> err_pulse one cycle, seq_error=1, err_count=1, state FAULT; then 1011 -> locked=1.
REQ-034 Inject 20 errors with ERR_CNT_W=4 -> err_count saturates at 15; clear_err coinciding with a 21st error -> err_count=1, seq_error=1.
REQ-035 Count 0110 (even) after reset -> remains SYNC, locked=0, no pulses; then 0111 -> locked=1.
REQ-036 Assert reset asynchronously mid-run at wrap_count=3 -> all outputs 0 immediately; relock on the next odd value.
